// File: rtl/align_shift_ctrl.sv
// Alignment-shift sequencer: clamps exponent differences into shift amounts, drives the
// external shifter for one cycle, captures its result and derives the sticky bits.
module align_shift_ctrl #(
  parameter int DW    = 76,
  parameter int SHW   = 12,
  parameter int D_MAX = 76,
  parameter int S_MAX = 38
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [1:0]     req_mode,
  input  logic [DW-1:0]  req_data,
  input  logic [12:0]    req_diff_d,
  input  logic [7:0]     req_diff_hi,
  input  logic [7:0]     req_diff_lo,
  output logic [DW-1:0]  sh_in,
  output logic [2:0]     sh_cont,
  output logic [SHW-1:0] sh_amt,
  input  logic [DW-1:0]  sh_out,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [1:0]     out_sticky,
  output logic           out_err
);

  localparam int       LW        = 37;
  localparam logic [2:0] CONT_QUIET = 3'b011;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [DW-1:0]   r_sh_in;
  logic [2:0]      r_sh_cont;
  logic [SHW-1:0]  r_sh_amt;
  logic            w_accept, w_release;
  logic [SHW-1:0]  w_req_amt;
  logic [DW-1:0]   w_mask_d;
  logic [5:0]      w_amt_h, w_amt_l;
  logic [LW-1:0]   w_mask_h, w_mask_l;
  logic [1:0]      w_sticky;

  function automatic logic [SHW-1:0] clamp_d(input logic [12:0] d);
    if (d[12]) return '0;
    if (d[11:0] > 12'(D_MAX)) return SHW'(D_MAX);
    return SHW'(d[11:0]);
  endfunction

  function automatic logic [5:0] clamp_s(input logic [7:0] d);
    if (d[7]) return '0;
    if (d[6:0] > 7'(S_MAX)) return 6'(S_MAX);
    return d[5:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_next = S_SHIFT;
      S_SHIFT: w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE) && !rst;
  end

  assign w_accept  = req_valid && req_ready;
  assign w_release = (r_state == S_DONE) && out_ready;

  always_comb begin
    w_req_amt = '0;
    case (req_mode)
      2'b00, 2'b10: w_req_amt = clamp_d(req_diff_d);
      2'b01:        w_req_amt = SHW'({clamp_s(req_diff_hi), clamp_s(req_diff_lo)});
      default:      w_req_amt = '0;
    endcase
  end

  // Masks select the bits that fall off the low end of the word / each lane.
  assign w_amt_h  = r_sh_amt[11:6];
  assign w_amt_l  = r_sh_amt[5:0];
  assign w_mask_d = (r_sh_amt >= SHW'(DW)) ? '1 : ((DW'(1) << r_sh_amt) - DW'(1));
  assign w_mask_h = (w_amt_h >= 6'(LW)) ? '1 : ((LW'(1) << w_amt_h) - LW'(1));
  assign w_mask_l = (w_amt_l >= 6'(LW)) ? '1 : ((LW'(1) << w_amt_l) - LW'(1));

  always_comb begin
    w_sticky = '0;
    case (r_sh_cont)
      3'b000, 3'b010: w_sticky[0] = |(r_sh_in & w_mask_d);
      3'b001:         w_sticky = {|(r_sh_in[74:38] & w_mask_h), |(r_sh_in[36:0] & w_mask_l)};
      default:        w_sticky = '0;
    endcase
  end

  // Shifter controls reset to the idle-quiet code so the shifter outputs 0 outside an op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_in    <= '0;
      r_sh_cont  <= CONT_QUIET;
      r_sh_amt   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sticky <= '0;
      out_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sh_in   <= req_data;
        r_sh_cont <= {1'b0, req_mode};
        r_sh_amt  <= w_req_amt;
      end else if (w_release) begin
        r_sh_in   <= '0;
        r_sh_cont <= CONT_QUIET;
        r_sh_amt  <= '0;
      end
      if (r_state == S_SHIFT) begin
        out_data   <= (r_sh_cont == CONT_QUIET) ? '0 : sh_out;
        out_sticky <= w_sticky;
        out_err    <= (r_sh_cont == CONT_QUIET);
        out_valid  <= 1'b1;
      end else if (w_release) begin
        out_valid <= 1'b0;
        out_err   <= 1'b0;
      end
    end
  end

  assign sh_in   = r_sh_in;
  assign sh_cont = r_sh_cont;
  assign sh_amt  = r_sh_amt;

endmodule

// File: tb/tb_align_shift_ctrl.sv
// Bench for align_shift_ctrl: behavioural shifter stand-in plus a clamp/shift/sticky
// reference model, directed vectors and randomized operations.
module tb_align_shift_ctrl;
  localparam int DW = 76;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid, req_ready, out_valid, out_ready, out_err;
  logic [1:0]    req_mode, out_sticky;
  logic [DW-1:0] req_data, sh_in, sh_out, out_data;
  logic [12:0]   req_diff_d;
  logic [7:0]    req_diff_hi, req_diff_lo;
  logic [2:0]    sh_cont;
  logic [11:0]   sh_amt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  align_shift_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_data(req_data), .req_diff_d(req_diff_d),
    .req_diff_hi(req_diff_hi), .req_diff_lo(req_diff_lo), .sh_in(sh_in),
    .sh_cont(sh_cont), .sh_amt(sh_amt), .sh_out(sh_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sticky(out_sticky), .out_err(out_err)
  );

  // Stand-in for the combinational shifter.
  always_comb begin
    logic [36:0] hi, lo;
    hi = sh_in[74:38];
    lo = sh_in[36:0];
    sh_out = '0;
    case (sh_cont)
      3'b000, 3'b010: sh_out = (sh_amt >= 12'd76) ? '0 : (sh_in >> sh_amt);
      3'b001:         sh_out = {1'b0, hi >> sh_amt[11:6], 1'b0, lo >> sh_amt[5:0]};
      default:        sh_out = '0;
    endcase
  end

  function automatic int clampi(int d, int mx);
    if (d < 0) return 0;
    if (d > mx) return mx;
    return d;
  endfunction

  function automatic logic or_low(logic [75:0] v, int n);
    logic r = 1'b0;
    for (int i = 0; i < n && i < 76; i++) r |= v[i];
    return r;
  endfunction

  task automatic ref_model(input logic [1:0] m, input logic [75:0] d, input logic [12:0] dd,
                           input logic [7:0] dh, input logic [7:0] dl,
                           output logic [75:0] od, output logic [1:0] st, output logic e,
                           output logic [11:0] amt);
    int a, ah, al;
    logic [36:0] hi, lo;
    hi = d[74:38];
    lo = d[36:0];
    od = '0; st = '0; e = 1'b0; amt = '0;
    case (m)
      2'b00, 2'b10: begin
        a   = clampi(int'($signed(dd)), 76);
        amt = 12'(a);
        od  = (a >= 76) ? '0 : d >> a;
        st  = {1'b0, or_low(d, a)};
      end
      2'b01: begin
        ah  = clampi(int'($signed(dh)), 38);
        al  = clampi(int'($signed(dl)), 38);
        amt = 12'(ah * 64 + al);
        od  = {1'b0, hi >> ah, 1'b0, lo >> al};
        st  = {or_low({39'b0, hi}, ah), or_low({39'b0, lo}, al)};
      end
      default: e = 1'b1;
    endcase
  endtask

  // Drives one request with out_ready high; lat counts negedges from drive until out_valid.
  task automatic run_op(input logic [1:0] m, input logic [75:0] d, input logic [12:0] dd,
                        input logic [7:0] dh, input logic [7:0] dl,
                        output logic [11:0] amt, output logic [2:0] cont,
                        output logic [75:0] od, output logic [1:0] st, output logic e,
                        output int lat);
    @(negedge clk);
    req_mode = m; req_data = d; req_diff_d = dd; req_diff_hi = dh; req_diff_lo = dl;
    req_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    lat = 1; amt = sh_amt; cont = sh_cont;
    req_valid = 1'b0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    od = out_data; st = out_sticky; e = out_err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if ({out_data, out_sticky, out_err} !== '0) begin errors++; $display("FAIL reset_outputs: data %h sticky %b err %b want 0", out_data, out_sticky, out_err); end
    checks++; if ({sh_in, sh_amt} !== '0) begin errors++; $display("FAIL reset_shifter: sh_in %h sh_amt %h want 0", sh_in, sh_amt); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b want 1", req_ready); end
    checks++; if (sh_cont !== 3'b011) begin errors++; $display("FAIL idle_sh_cont: got %b want 011", sh_cont); end
  endtask

  task automatic test_double();
    logic [11:0] amt; logic [2:0] cont; logic [75:0] od, d; logic [1:0] st; logic e; int lat;
    d = 76'h1 << 40;
    run_op(2'b00, d, 13'd8, 8'd0, 8'd0, amt, cont, od, st, e, lat);
    checks++; if (cont !== 3'b000 || amt !== 12'd8) begin errors++; $display("FAIL dbl_ctrl: cont %b amt %0d want 000/8", cont, amt); end
    checks++; if (od !== (76'h1 << 32) || st !== 2'b00) begin errors++; $display("FAIL dbl_data: %h/%b want %h/00", od, st, 76'h1 << 32); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL dbl_latency: got %0d want 2", lat); end
    run_op(2'b00, 76'hFF, 13'h1FFB, 8'd0, 8'd0, amt, cont, od, st, e, lat);
    checks++; if (amt !== 12'd0 || od !== 76'hFF || st !== 2'b00) begin errors++; $display("FAIL dbl_neg: amt %0d data %h st %b want 0/FF/00", amt, od, st); end
    run_op(2'b00, 76'hFF, 13'd200, 8'd0, 8'd0, amt, cont, od, st, e, lat);
    checks++; if (amt !== 12'd76 || od !== 76'h0 || st !== 2'b01) begin errors++; $display("FAIL dbl_sat: amt %0d data %h st %b want 76/0/01", amt, od, st); end
  endtask

  task automatic test_dual();
    logic [11:0] amt; logic [2:0] cont; logic [75:0] od, d; logic [1:0] st; logic e; int lat;
    d = {1'b0, 37'h1F, 1'b0, 37'h10};
    run_op(2'b01, d, 13'd0, 8'd3, 8'd4, amt, cont, od, st, e, lat);
    checks++; if (cont !== 3'b001 || amt !== 12'o0304) begin errors++; $display("FAIL dual_ctrl: cont %b amt %o want 001/0304", cont, amt); end
    checks++; if (od !== {1'b0, 37'h3, 1'b0, 37'h1} || st !== 2'b10) begin errors++; $display("FAIL dual_data: %h/%b want lanes 3,1 sticky 10", od, st); end
    run_op(2'b01, d, 13'd0, 8'd3, 8'd100, amt, cont, od, st, e, lat);
    checks++; if (amt !== {6'd3, 6'd38} || od !== {1'b0, 37'h3, 1'b0, 37'h0} || st !== 2'b11) begin errors++; $display("FAIL dual_sat: amt %o data %h st %b", amt, od, st); end
  endtask

  task automatic test_illegal();
    logic [11:0] amt; logic [2:0] cont; logic [75:0] od; logic [1:0] st; logic e; int lat;
    run_op(2'b11, 76'hABCDEF, 13'd3, 8'd1, 8'd1, amt, cont, od, st, e, lat);
    checks++; if (e !== 1'b1 || od !== 76'h0 || st !== 2'b00) begin errors++; $display("FAIL illegal: err %b data %h st %b want 1/0/00", e, od, st); end
    checks++; if (cont !== 3'b011 || lat !== 2) begin errors++; $display("FAIL illegal_ctrl: cont %b lat %0d want 011/2", cont, lat); end
    checks++; if (out_err !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL illegal_clear: err %b valid %b want 0/0", out_err, out_valid); end
  endtask

  task automatic test_backpressure();
    logic [75:0] held; int bad = 0; int n = 0;
    @(negedge clk);
    req_mode = 2'b00; req_data = 76'h1234_5678; req_diff_d = 13'd4; req_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    req_data = 76'h9999;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    held = out_data;
    checks++; if (held !== 76'h123_4567) begin errors++; $display("FAIL bp_data: got %h want %h", held, 76'h123_4567); end
    repeat (5) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== held || req_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stall: %0d unstable cycles want 0", bad); end
    out_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || req_ready !== 1'b1 || out_data !== held) begin errors++; $display("FAIL bp_release: valid %b ready %b data %h", out_valid, req_ready, out_data); end
  endtask

  task automatic test_back_to_back();
    int done = 0; int bad = 0;
    @(negedge clk);
    req_mode = 2'b10; req_data = 76'hF0F0; req_diff_d = 13'd4; req_valid = 1'b1; out_ready = 1'b1;
    repeat (9) begin
      @(negedge clk);
      if (out_valid) begin
        done++;
        if (out_data !== 76'hF0F || out_sticky !== 2'b00) bad++;
      end
    end
    req_valid = 1'b0;
    checks++; if (done != 3 || bad != 0) begin errors++; $display("FAIL back_to_back: %0d ops %0d bad want 3/0", done, bad); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rose = 0;
    @(negedge clk);
    req_mode = 2'b00; req_data = 76'hFFFF; req_diff_d = 13'd2; req_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_during: ready %b valid %b want 0/0", req_ready, out_valid); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b want 1", req_ready); end
    repeat (4) begin @(negedge clk); if (out_valid) rose++; end
    checks++; if (rose != 0) begin errors++; $display("FAIL rst_mid_valid: out_valid rose %0d times want 0", rose); end
  endtask

  task automatic test_random();
    logic [11:0] amt, eamt; logic [2:0] cont; logic [75:0] od, eod, d; logic [1:0] st, est, m;
    logic e, ee; logic [12:0] dd; logic [7:0] dh, dl; int lat; int r;
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      m  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      d  = 76'({$urandom(), $urandom(), $urandom()});
      dd = $urandom_range(0, 1) ? 13'($urandom()) : 13'($urandom_range(0, 90));
      dh = $urandom_range(0, 1) ? 8'($urandom()) : 8'($urandom_range(0, 45));
      dl = $urandom_range(0, 1) ? 8'($urandom()) : 8'($urandom_range(0, 45));
      ref_model(m, d, dd, dh, dl, eod, est, ee, eamt);
      run_op(m, d, dd, dh, dl, amt, cont, od, st, e, lat);
      checks++; if (od !== eod) begin errors++; $display("FAIL rnd%0d_data: mode %0d got %h want %h", i, m, od, eod); end
      checks++; if (st !== est || e !== ee) begin errors++; $display("FAIL rnd%0d_flags: st %b err %b want %b %b", i, st, e, est, ee); end
      checks++; if (cont !== {1'b0, m} || lat !== 2) begin errors++; $display("FAIL rnd%0d_ctrl: cont %b lat %0d want %b/2", i, cont, lat, {1'b0, m}); end
      if (m != 2'b11) begin
        checks++; if (amt !== eamt) begin errors++; $display("FAIL rnd%0d_amt: got %0d want %0d", i, amt, eamt); end
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; out_ready = 1'b0; req_mode = '0; req_data = '0;
    req_diff_d = '0; req_diff_hi = '0; req_diff_lo = '0;
    test_reset();
    test_double();
    test_dual();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
